adder4_seq_ctrl: RTL and testbench



---
 rtl/adder4_seq_ctrl.sv | 116 +++++++++++
 tb/tb_adder4_seq_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/adder4_seq_ctrl.sv
// Multi-cycle W-bit adder: one 4-bit adder slice is reused for each nibble, low nibble first,
// with a carry register between nibbles. start/busy/done handshake; sum and c_out hold between runs.
module adder4_seq_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*WORDS-1:0]   a,
  input  logic [4*WORDS-1:0]   b,
  input  logic                 c_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*WORDS-1:0]   sum,
  output logic                 c_out,
  output logic [1:0]           dbg_state
);

  // Handshake: start is sampled only in IDLE; a request there is accepted on that
  // same edge. busy is high for the WORDS cycles of RUN. done pulses for one cycle in DONE.
  // start seen in RUN or DONE is dropped, not queued.

  localparam int W  = 4 * WORDS;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  s_q, s_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          c_out_q, c_out_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [4:0]    slice;
  logic [W-1:0]  s_shift;

  always_comb begin
    // The 4-bit adder slice works on the low nibble of the operand shift registers.
    slice   = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, carry_q};
    // The new nibble enters at the top, so after WORDS shifts the sum lines up with bit 0.
    s_shift = (s_q >> 4) | (W'(slice[3:0]) << (W - 4));

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          cnt_d   = '0;
          s_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        s_d     = s_shift;
        carry_d = slice[4];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = s_shift;
          c_out_d = slice[4];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_adder4_seq_ctrl.sv
// Directed and random bench for adder4_seq_ctrl (WORDS=4): expected {c_out,sum} from a+b+c_in
// are queued at each start and checked, together with handshake timing, when done pulses.
module tb_adder4_seq_ctrl;

  localparam int WORDS = 4;
  localparam int W     = 4 * WORDS;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          c_in;
  logic          busy;
  logic          done;
  logic [W-1:0]  sum;
  logic          c_out;
  logic [1:0]    dbg_state;

  logic [W:0]    exp_q[$];
  logic [W:0]    hold_exp;
  int            vectors;
  int            miscompares;

  adder4_seq_ctrl #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .c_out     (c_out),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " busy"},  {16'd0, busy},  17'd0);
    chk({tag, " done"},  {16'd0, done},  17'd0);
    chk({tag, " sum"},   {c_out, sum},   17'd0);
    chk({tag, " state"}, {15'd0, dbg_state}, 17'd0);
  endtask

  // Driver: one operation. glitch=1 pulses start with other operands while busy.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic op_c, input bit glitch);
    int n;
    logic [W:0] exp;
    @(negedge clk);
    a = op_a; b = op_b; c_in = op_c; start = 1'b1;
    exp_q.push_back({1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, op_c});
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      chk("busy during run", {16'd0, busy}, 17'd1);
      chk("sum held during run", {c_out, sum}, hold_exp);
      if (glitch && n == 1) begin
        a = '1; b = '1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("latency", 17'(n), 17'(WORDS));
    chk("busy at done", {16'd0, busy}, 17'd0);
    if (exp_q.size() == 0) begin
      chk("queue empty at done", 17'd1, 17'd0);
    end else begin
      exp = exp_q.pop_front();
      chk("result", {c_out, sum}, exp);
      hold_exp = exp;
    end
    @(posedge clk);
    @(negedge clk);
    chk("done one cycle", {16'd0, done}, 17'd0);
    chk("result held", {c_out, sum}, hold_exp);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    hold_exp    = '0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    #3;
    chk_idle_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    run_op(16'hABCD, 16'h6789, 1'b1, 1'b0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b1);
    // No second operation may follow the ignored start.
    repeat (WORDS + 2) begin
      @(negedge clk);
      chk("no extra op busy", {16'd0, busy}, 17'd0);
      chk("no extra op done", {16'd0, done}, 17'd0);
    end

    // Reset during a run discards it and clears the held result.
    @(negedge clk);
    a = 16'h7777; b = 16'h8888; c_in = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_zero("reset mid-run");
    hold_exp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);

    repeat (4) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom_range(0, 16'hFFFF));
      rb = W'($urandom_range(0, 16'hFFFF));
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'b0);
    end

    chk("queue drained", 17'(exp_q.size()), 17'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
